// File: rtl/nes_multi_pad_reader.sv
// Polls NUM_PADS NES/SNES controllers in parallel over a shared latch/clock pair.
// Optional macro NES_PAD_DEBOUNCE_EN: a pad's buttons update only when two consecutive raw frames agree.
module nes_multi_pad_reader #(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 8,
  parameter int CLK_DIV     = 300,
  parameter int POLL_CYCLES = 800000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PADS-1:0]          nesData,
  output logic                         nesLatch,
  output logic                         nesClk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic                         valid,
  output logic                         busy
);

  localparam int LATCH_LEN = 2 * CLK_DIV;
  localparam int CNT_MAX   = (POLL_CYCLES > LATCH_LEN) ? POLL_CYCLES : LATCH_LEN;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int BW        = $clog2(NUM_BITS + 1);
  localparam int FW        = NUM_PADS * NUM_BITS;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_POLL  = CW'(POLL_CYCLES);
  localparam logic [CW-1:0] CNT_LATCH = CW'(LATCH_LEN);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [BW-1:0]  bit_r, bit_s;
  logic           sample_s;
  logic [FW-1:0]  raw_r;
`ifdef NES_PAD_DEBOUNCE_EN
  logic [FW-1:0]  prev_raw_r;
`endif

  // Next-state, phase counter and sample strobe; cnt counts down to 1 in every timed state.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r - CNT_ONE;
    bit_s    = bit_r;
    sample_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cnt_r == CNT_ONE) begin
          state_s = LATCH;
          cnt_s   = CNT_LATCH;
          bit_s   = BIT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      LATCH: begin
        if (cnt_r == CNT_ONE) begin
          sample_s = 1'b1;
          bit_s    = bit_r + BIT_ONE;
          cnt_s    = CNT_HALF;
          state_s  = (NUM_BITS == 1) ? DONE : CLK_LO;
        end else begin
          state_s = LATCH;
        end
      end
      CLK_LO: begin
        if (cnt_r == CNT_ONE) begin
          state_s = CLK_HI;
          cnt_s   = CNT_HALF;
        end else begin
          state_s = CLK_LO;
        end
      end
      CLK_HI: begin
        if (cnt_r == CNT_ONE) begin
          sample_s = 1'b1;
          bit_s    = bit_r + BIT_ONE;
          cnt_s    = CNT_HALF;
          state_s  = (bit_r == BIT_LAST) ? DONE : CLK_LO;
        end else begin
          state_s = CLK_HI;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = CNT_POLL;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_POLL;
        bit_s   = BIT_ZERO;
      end
    endcase
  end

  // FSM state register; pad outputs are decoded from the next state so they stay aligned with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_POLL;
      bit_r    <= BIT_ZERO;
      nesLatch <= 1'b0;
      nesClk   <= 1'b1;
      busy     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      nesLatch <= (state_s == LATCH);
      nesClk   <= (state_s != CLK_LO);
      busy     <= (state_s != IDLE);
      valid    <= (state_r == DONE);
    end
  end

  // Raw capture and frame commit; a partial frame never reaches buttons because commit needs DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      raw_r   <= {FW{1'b0}};
      buttons <= {FW{1'b0}};
      pressed <= {FW{1'b0}};
`ifdef NES_PAD_DEBOUNCE_EN
      prev_raw_r <= {FW{1'b0}};
`endif
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (sample_s) begin
          raw_r[p*NUM_BITS + int'(bit_r)] <= ~nesData[p];
        end
      end
      if (state_r == DONE) begin
`ifdef NES_PAD_DEBOUNCE_EN
        for (int p = 0; p < NUM_PADS; p++) begin
          if (raw_r[p*NUM_BITS +: NUM_BITS] == prev_raw_r[p*NUM_BITS +: NUM_BITS]) begin
            buttons[p*NUM_BITS +: NUM_BITS] <= raw_r[p*NUM_BITS +: NUM_BITS];
            pressed[p*NUM_BITS +: NUM_BITS] <= raw_r[p*NUM_BITS +: NUM_BITS] &
                                               ~buttons[p*NUM_BITS +: NUM_BITS];
          end else begin
            pressed[p*NUM_BITS +: NUM_BITS] <= {NUM_BITS{1'b0}};
          end
        end
        prev_raw_r <= raw_r;
`else
        buttons <= raw_r;
        pressed <= raw_r & ~buttons;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nes_multi_pad_reader.sv
// Randomized self-checking bench: emulated shift-register pads feed the reader, a frame-level
// model predicts buttons/pressed, and waveform timing is measured per frame.
module tb_nes_multi_pad_reader;

  localparam int NP = 2;
  localparam int NB = 8;
  localparam int CD = 4;
  localparam int PC = 100;
  localparam int FW = NP * NB;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] nesData;
  logic          nesLatch;
  logic          nesClk;
  logic [FW-1:0] buttons;
  logic [FW-1:0] pressed;
  logic          valid;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] pad_btn [NP];
  int            pad_idx = NB;
  logic          pad_prev_clk = 1'b1;

  logic [FW-1:0] m_buttons = '0;
  logic [FW-1:0] m_pressed = '0;
  logic [FW-1:0] m_prev    = '0;

  int   rises;
  int   cyc;
  logic pc_abort;

  nes_multi_pad_reader #(
    .NUM_PADS(NP), .NUM_BITS(NB), .CLK_DIV(CD), .POLL_CYCLES(PC)
  ) dut (
    .clk(clk), .reset(reset), .nesData(nesData), .nesLatch(nesLatch), .nesClk(nesClk),
    .buttons(buttons), .pressed(pressed), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Controller emulation: latch reloads the shift position, each nesClk rise shifts one button out.
  always @(negedge clk) begin
    if (nesLatch) pad_idx = 0;
    else if (nesClk && !pad_prev_clk) pad_idx = pad_idx + 1;
    pad_prev_clk = nesClk;
    for (int p = 0; p < NP; p++)
      nesData[p] = (pad_idx < NB) ? ~pad_btn[p][pad_idx] : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level expectation from the pads' button sets.
  task automatic model_frame();
    logic [FW-1:0] nf;
    for (int p = 0; p < NP; p++) nf[p*NB +: NB] = pad_btn[p];
`ifdef NES_PAD_DEBOUNCE_EN
    for (int p = 0; p < NP; p++) begin
      if (nf[p*NB +: NB] == m_prev[p*NB +: NB]) begin
        m_pressed[p*NB +: NB] = nf[p*NB +: NB] & ~m_buttons[p*NB +: NB];
        m_buttons[p*NB +: NB] = nf[p*NB +: NB];
      end else begin
        m_pressed[p*NB +: NB] = '0;
      end
    end
    m_prev = nf;
`else
    m_pressed = nf & ~m_buttons;
    m_buttons = nf;
`endif
  endtask

  // Runs until the next valid pulse, measuring latch/clock timing and checking results.
  task automatic run_frame(input string tag);
    int n = 0, lat = 0, lop = 0, loc = 0, bsy = 0, ovl = 0, first_lat = 0, hold_err = 0;
    logic got = 1'b0;
    logic pc = nesClk;
    while (!got && n < 2000) begin
      @(negedge clk);
      n++;
      if (nesLatch) begin
        lat++;
        if (first_lat == 0) first_lat = n;
      end
      if (!nesClk) loc++;
      if (!nesClk && pc) lop++;
      pc = nesClk;
      if (busy) bsy++;
      if (nesLatch && !nesClk) ovl++;
      if (valid) got = 1'b1;
      else if (buttons !== m_buttons || pressed !== m_pressed) hold_err++;
    end
    model_frame();
    chk({tag, ":valid_seen"}, 32'(got), 32'd1);
    chk({tag, ":period"}, n, PC + 2*CD*NB + 1);
    chk({tag, ":latch_rise"}, first_lat, PC);
    chk({tag, ":latch_len"}, lat, 2*CD);
    chk({tag, ":clk_pulses"}, lop, NB - 1);
    chk({tag, ":clk_low_cycles"}, loc, (NB - 1) * CD);
    chk({tag, ":busy_len"}, bsy, 2*CD*NB + 1);
    chk({tag, ":latch_clk_overlap"}, ovl, 0);
    chk({tag, ":hold"}, hold_err, 0);
    chk({tag, ":buttons"}, 32'(buttons), 32'(m_buttons));
    chk({tag, ":pressed"}, 32'(pressed), 32'(m_pressed));
  endtask

  initial begin
    reset = 1'b0;
    for (int p = 0; p < NP; p++) pad_btn[p] = '0;
    repeat (3) @(negedge clk);
    chk("rst:nesLatch", 32'(nesLatch), 32'd0);
    chk("rst:nesClk", 32'(nesClk), 32'd1);
    chk("rst:buttons", 32'(buttons), 32'd0);
    chk("rst:pressed", 32'(pressed), 32'd0);
    chk("rst:valid", 32'(valid), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    reset = 1'b1;

    run_frame("idle");
    pad_btn[0] = 8'h81;
    run_frame("a_right");
    run_frame("a_right_repeat");
    pad_btn[0] = 8'h80;
    run_frame("release_a");

    pad_btn[0] = 8'h02;
    run_frame("b_once");
    pad_btn[0] = 8'h00;
    run_frame("b_released");
    pad_btn[0] = 8'h02;
    run_frame("b_first");
    run_frame("b_second");

    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < NP; p++) pad_btn[p] = 8'($urandom);
      if (f >= 4) run_frame("rand_repeat");
      else run_frame("rand");
      if (f == 3) run_frame("rand_stable");
    end

    // Abort a frame during the high phase of bit 4.
    pad_btn[0] = 8'($urandom) | 8'h01;
    pad_btn[1] = 8'($urandom);
    rises = 0;
    cyc = 0;
    pc_abort = nesClk;
    while (rises < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (nesClk && !pc_abort) rises++;
      pc_abort = nesClk;
    end
    chk("abort:reach_bit4", rises, 4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort:nesClk", 32'(nesClk), 32'd1);
    chk("abort:nesLatch", 32'(nesLatch), 32'd0);
    chk("abort:valid", 32'(valid), 32'd0);
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:buttons", 32'(buttons), 32'd0);
    chk("abort:pressed", 32'(pressed), 32'd0);
    m_buttons = '0;
    m_pressed = '0;
    m_prev    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_frame("post_abort");
    run_frame("post_abort_repeat");
    for (int p = 0; p < NP; p++) pad_btn[p] = 8'($urandom);
    run_frame("final_rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
